// File: rtl/jpeg_enc_pkg.sv
// Shared types and constants for the JPEG entropy-coder output path.
// Marker bytes on flush are enabled by defining JPEG_EOI_EN.
package jpeg_enc_pkg;

  typedef enum logic [2:0] {
    RUN,
    STUFF,
    PAD,
    EOI1,
    EOI2,
    FDONE
  } state_e;

  localparam logic [7:0] JPEG_STUFF_BYTE = 8'h00;
  localparam logic [7:0] JPEG_FF         = 8'hFF;
  localparam logic [7:0] JPEG_EOI_LO     = 8'hD9;
  localparam int         MAX_CODE_BITS   = 8;

  // Keep the top n bits of b, fill the rest with pb
  function automatic logic [7:0] pad_byte(
    input logic [7:0] b,
    input logic [4:0] n,
    input logic       pb
  );
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if ((7 - i) >= int'(n)) r[i] = pb;
      else r[i] = b[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/jpeg_bit_accumulator.sv
// Left-justified bit accumulator: shift-out of a byte, then merge of a code chunk.
// Occupancy is bounded to ACC_W bits by the caller's accept rule.
module jpeg_bit_accumulator
  import jpeg_enc_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       take,
  input  logic [7:0] bits,
  input  logic [3:0] nbits,
  input  logic       shift,
  input  logic       clear,
  output logic [7:0] acc_hi,
  output logic [4:0] cnt
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_s;
  logic [ACC_W-1:0] acc_d;
  logic [4:0]       cnt_q;
  logic [4:0]       cnt_s;
  logic [4:0]       cnt_d;
  logic [4:0]       sh;
  logic [7:0]       masked;

  always_comb begin
    acc_s  = shift ? (acc_q << 8) : acc_q;
    cnt_s  = shift ? (cnt_q - 5'd8) : cnt_q;
    masked = bits & (8'hFF >> (4'd8 - nbits));
    sh     = 5'(ACC_W) - cnt_s - {1'b0, nbits};
    acc_d  = acc_s;
    cnt_d  = cnt_s;
    if (take) begin
      acc_d = acc_s | (ACC_W'(masked) << sh);
      cnt_d = cnt_s + {1'b0, nbits};
    end
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_hi = acc_q[ACC_W-1:ACC_W-8];
  assign cnt    = cnt_q;

endmodule

// File: rtl/jpeg_bitstream_packer.sv
// Packs Huffman code chunks MSB-first into stuffed bytes with pad-on-flush.
// Define JPEG_EOI_EN to append the FF D9 end-of-image marker on flush.
module jpeg_bitstream_packer
  import jpeg_enc_pkg::*;
#(
  parameter int   ACC_W   = 16,
  parameter logic PAD_BIT = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_bits,
  input  logic [3:0] in_nbits,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       flush_done
);

`ifdef JPEG_EOI_EN
  localparam state_e TAIL = EOI1;
`else
  localparam state_e TAIL = FDONE;
`endif

  state_e     state_q;
  state_e     state_d;
  logic       pend_q;
  logic       pend_d;
  logic       live_q;
  logic       take;
  logic       can_load;
  logic       load;
  logic [7:0] load_byte;
  logic       shift;
  logic       clear;
  logic [3:0] nbits;
  logic [7:0] acc_hi;
  logic [4:0] cnt;
  logic [7:0] padded;

  assign nbits = (in_nbits > 4'(MAX_CODE_BITS)) ?
                 4'(MAX_CODE_BITS) : in_nbits;

  assign in_ready = live_q && (state_q == RUN) &&
                    (cnt <= 5'd8) && !pend_q;

  assign take     = in_valid && in_ready;
  assign can_load = !out_valid || out_ready;
  assign padded   = pad_byte(acc_hi, cnt, PAD_BIT);

  jpeg_bit_accumulator #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .take    (take),
    .bits    (in_bits),
    .nbits   (nbits),
    .shift   (shift),
    .clear   (clear),
    .acc_hi  (acc_hi),
    .cnt     (cnt)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    load       = 1'b0;
    load_byte  = JPEG_STUFF_BYTE;
    shift      = 1'b0;
    clear      = 1'b0;
    flush_done = 1'b0;
    unique case (state_q)
      RUN: begin
        if (flush && !pend_q) pend_d = 1'b1;
        if (cnt >= 5'd8) begin
          if (can_load) begin
            load      = 1'b1;
            load_byte = acc_hi;
            shift     = 1'b1;
            if (acc_hi == JPEG_FF) state_d = STUFF;
          end
        end else if (pend_q) begin
          state_d = (cnt != 5'd0) ? PAD : TAIL;
        end
      end
      STUFF: begin
        if (can_load) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      PAD: begin
        if (can_load) begin
          load      = 1'b1;
          load_byte = padded;
          clear     = 1'b1;
          // a padded FF is stuffed; RUN then sees cnt==0 and moves on
          state_d   = (padded == JPEG_FF) ? STUFF : TAIL;
        end
      end
`ifdef JPEG_EOI_EN
      EOI1: begin
        if (can_load) begin
          load      = 1'b1;
          load_byte = JPEG_FF;
          state_d   = EOI2;
        end
      end
      EOI2: begin
        if (can_load) begin
          load      = 1'b1;
          load_byte = JPEG_EOI_LO;
          state_d   = FDONE;
        end
      end
`endif
      FDONE: begin
        if (!out_valid) begin
          flush_done = 1'b1;
          pend_d     = 1'b0;
          clear      = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      live_q  <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_byte;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Scoreboard bench for jpeg_bitstream_packer: directed chunks, flushes,
// backpressure and mid-stream reset, bytes checked by a separate monitor.
module tb_jpeg_bitstream_packer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_bits = 8'h00;
  logic [3:0] in_nbits = 4'd0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       flush_done;

  int checks = 0;
  int errors = 0;
  int fd_expect = 0;
  logic [7:0] exp_q[$];

  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  always #5 clock = ~clock;

  jpeg_bitstream_packer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .in_nbits   (in_nbits),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush_done (flush_done)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops expected bytes, checks hold under backpressure
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) chk("hold_stable", {23'd0, out_valid, out_data},
                      {23'd0, 1'b1, hold_d});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          chk("out_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      hold_v <= out_valid && !out_ready;
      hold_d <= out_data;
      if (flush_done) begin
        chk("flush_done_expected", (fd_expect > 0), 1);
        chk("flush_done_after_bytes", exp_q.size(), 0);
        if (fd_expect > 0) fd_expect--;
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic [3:0] n);
    int k;
    @(negedge clock);
    in_valid = 1'b1;
    in_bits  = b;
    in_nbits = n;
    k = 0;
    while (!in_ready && k < 300) begin
      @(negedge clock);
      k++;
    end
    if (k >= 300) chk("in_ready_timeout", 0, 1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    int k;
    @(negedge clock);
    fd_expect++;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    k = 0;
    while (!flush_done && k < 300) begin
      @(negedge clock);
      k++;
    end
    if (k >= 300) chk("flush_done_timeout", 0, 1);
    @(negedge clock);
    chk("in_ready_after_flush", in_ready, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clock);
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flush_done", flush_done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("in_ready_after_rst", in_ready, 1);

    // 1: nibble packing
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h12);
    send(8'h0A, 4'd4);
    send(8'h05, 4'd4);
    send(8'h12, 4'd8);
    send(8'h00, 4'd0);
    drain();

    // 2: stuffing
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h3C);
    send(8'hFF, 4'd8);
    send(8'h3C, 4'd8);
    drain();

    // 3: pad on flush
    exp_q.push_back(8'hBF);
`ifdef JPEG_EOI_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
`endif
    send(8'h05, 4'd3);
    do_flush();

    // 4: padded byte becomes FF and is stuffed
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
`ifdef JPEG_EOI_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
`endif
    send(8'h7F, 4'd7);
    do_flush();

    // 5: backpressure
    @(negedge clock);
    out_ready = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    send(8'h01, 4'd8);
    send(8'h02, 4'd8);
    send(8'h03, 4'd8);
    repeat (10) @(negedge clock);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data", out_data, 8'h01);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    drain();

    // 6: reset with buffered bits and a held byte
    @(negedge clock);
    out_ready = 1'b0;
    exp_q.push_back(8'hAA);
    send(8'hAA, 4'd8);
    send(8'h1F, 4'd5);
    @(negedge clock);
    chk("pre_rst_out_valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(8'h80);
    send(8'h80, 4'd8);
    drain();
    repeat (20) @(negedge clock);
    chk("no_extra_flush_done", fd_expect, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
